// File: rtl/dff_pipe.sv
// dff_pipe: DEPTH-stage, N-bit register delay line with a valid bit per stage, stall (en) and flush.
// Latency: exactly DEPTH enabled edges from d/d_valid to q/q_valid; edges with en=0 do not count.
// Backpressure: en=0 freezes every stage; there is no ready output, so upstream must honour the stall itself.
// Optional build macro DFF_PIPE_OCCUPANCY_EN adds a registered occ output (count of valid stages).
module dff_pipe #(
  parameter int              N       = 5,
  parameter int              DEPTH   = 4,
  parameter logic [N-1:0]    RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         flush,
  input  logic [N-1:0] d,
  input  logic         d_valid,
  output logic [N-1:0] q,
  output logic         q_valid,
  output logic         busy
`ifdef DFF_PIPE_OCCUPANCY_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

  // Data and valid live in separate registers because flush touches only the valid bits.
  logic [N-1:0]     stage_q [DEPTH];
  logic [DEPTH-1:0] valid_q;

  // Data stages: reset to RST_VAL, shift on an enabled edge, hold on flush or stall.
  // Data is captured whether or not d_valid is set; the valid bit marks bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RST_VAL;
      end
    end else if (!flush && en) begin
      stage_q[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  // Valid stages: cleared by reset or flush (flush drops the incoming sample), shifted when enabled.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q <= '0;
    end else if (en) begin
      valid_q[0] <= d_valid;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  // Outputs come straight from the last stage; busy depends on registers only.
  always_comb begin
    q       = stage_q[DEPTH-1];
    q_valid = valid_q[DEPTH-1];
    busy    = |valid_q;
  end

`ifdef DFF_PIPE_OCCUPANCY_EN
  localparam int OCC_W = $clog2(DEPTH+1);

  logic [OCC_W-1:0] occ_q;

  // Occupancy tracks the popcount of valid_q: +1 for a valid sample entering, -1 for one leaving.
  // Both happen on the same enabled edge, so the count stays within 0..DEPTH.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occ_q <= '0;
    end else if (en) begin
      occ_q <= occ_q + OCC_W'(d_valid) - OCC_W'(valid_q[DEPTH-1]);
    end
  end

  assign occ = occ_q;
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: directed plus randomized checks of dff_pipe against a delay-line model.
// Latency: model compares outputs 1 ns after every rising edge.
// Backpressure: stall and flush are driven as plain directed/random inputs.
module tb_dff_pipe;

  localparam int N     = 5;
  localparam int DEPTH = 4;
  localparam int OW    = $clog2(DEPTH+1);

  logic         clk = 1'b0;
  logic         rst, en, flush, d_valid;
  logic [N-1:0] d;
  logic [N-1:0] q;
  logic         q_valid, busy;
  logic [OW-1:0] occ;

  int compared   = 0;
  int mismatched = 0;

  // Model: every enabled edge appends its sample to a log. The output is the sample logged
  // DEPTH enabled edges ago. Reset hides everything logged before it (data reads RST_VAL),
  // flush hides the valid flag of everything logged before it but keeps the data.
  logic [N-1:0] log_d [$];
  bit           log_v [$];
  int           reset_mark = 0;
  int           flush_mark = 0;

  dff_pipe #(.N(N), .DEPTH(DEPTH), .RST_VAL('0)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .flush   (flush),
    .d       (d),
    .d_valid (d_valid),
    .q       (q),
    .q_valid (q_valid),
    .busy    (busy)
`ifdef DFF_PIPE_OCCUPANCY_EN
    ,
    .occ     (occ)
`endif
  );

`ifndef DFF_PIPE_OCCUPANCY_EN
  assign occ = '0;
`endif

  always #5 clk = ~clk;

  task automatic check_model(input string tag);
    int           idx;
    int           lo;
    int           cnt;
    logic [N-1:0] exp_q;
    logic         exp_v;
    int           exp_occ;
    cnt     = log_d.size();
    idx     = cnt - DEPTH;
    exp_q   = (idx >= reset_mark) ? log_d[idx] : '0;
    exp_v   = (idx >= flush_mark) ? log_v[idx] : 1'b0;
    lo      = (idx > flush_mark) ? idx : flush_mark;
    exp_occ = 0;
    for (int k = lo; k < cnt; k++) begin
      if (k >= 0 && log_v[k]) exp_occ++;
    end
    compared++;
    assert (q === exp_q) else begin
      mismatched++;
      $error("FAIL %s q: got %b want %b", tag, q, exp_q);
    end
    compared++;
    assert (q_valid === exp_v) else begin
      mismatched++;
      $error("FAIL %s q_valid: got %b want %b", tag, q_valid, exp_v);
    end
    compared++;
    assert (busy === (exp_occ != 0)) else begin
      mismatched++;
      $error("FAIL %s busy: got %b want %b", tag, busy, exp_occ != 0);
    end
`ifdef DFF_PIPE_OCCUPANCY_EN
    compared++;
    assert (occ === OW'(exp_occ)) else begin
      mismatched++;
      $error("FAIL %s occ: got %0d want %0d", tag, occ, exp_occ);
    end
`endif
  endtask

  // Apply one cycle of inputs, advance the model by the same edge, then compare.
  task automatic step(input string tag, input bit r, input bit f, input bit e,
                      input logic [N-1:0] dd, input bit dv);
    rst = r; flush = f; en = e; d = dd; d_valid = dv;
    @(posedge clk);
    if (r) begin
      reset_mark = log_d.size();
      flush_mark = reset_mark;
    end else if (f) begin
      flush_mark = log_d.size();
    end else if (e) begin
      log_d.push_back(dd);
      log_v.push_back(dv);
    end
    #1;
    check_model(tag);
  endtask

  // Plain constant checks of the test-plan expectations, independent of the model.
  task automatic expect_out(input string tag, input logic [N-1:0] eq, input logic ev, input logic eb);
    compared++;
    assert (q === eq && q_valid === ev && busy === eb) else begin
      mismatched++;
      $error("FAIL %s q/q_valid/busy: got %b/%b/%b want %b/%b/%b", tag, q, q_valid, busy, eq, ev, eb);
    end
  endtask

  initial begin
    logic [N-1:0] rd;
    logic [N-1:0] q_hold;
    rst = 1'b0; en = 1'b0; flush = 1'b0; d = '0; d_valid = 1'b0;
    @(negedge clk);

    // Reset with junk on the inputs.
    step("reset0", 1, 0, 1, 5'b11111, 1);
    step("reset1", 1, 0, 1, 5'b11111, 1);
    expect_out("reset_const", 5'b00000, 1'b0, 1'b0);

    // Basic latency: one valid sample then bubbles.
    step("lat0", 0, 0, 1, 5'b10101, 1);
    for (int k = 1; k < DEPTH; k++) step("lat_bub", 0, 0, 1, 5'(k), 0);
    expect_out("lat_const", 5'b10101, 1'b1, 1'b1);
    step("lat_after", 0, 0, 1, 5'b00111, 0);
    compared++;
    assert (q_valid === 1'b0) else begin
      mismatched++;
      $error("FAIL lat_one_cycle q_valid: got %b want 0", q_valid);
    end
    for (int k = 0; k < DEPTH; k++) step("lat_drain", 0, 0, 1, 5'b00000, 0);

    // Stall: capture, 2 more enabled edges, 3 stalled edges, then 1 enabled edge.
    step("stall_cap", 0, 0, 1, 5'b01010, 1);
    step("stall_en1", 0, 0, 1, 5'b00001, 0);
    step("stall_en2", 0, 0, 1, 5'b00010, 0);
    q_hold = q;
    for (int k = 0; k < 3; k++) begin
      step("stall_hold", 0, 0, 0, 5'b11111, 1);
      expect_out("stall_hold_const", q_hold, 1'b0, 1'b1);
    end
    step("stall_go", 0, 0, 1, 5'b00000, 0);
    expect_out("stall_out_const", 5'b01010, 1'b1, 1'b1);
    for (int k = 0; k < DEPTH; k++) step("stall_drain", 0, 0, 1, 5'b00000, 0);

    // Flush with two valid samples in flight and a valid sample on the input.
    step("fl_a", 0, 0, 1, 5'b00011, 1);
    step("fl_b", 0, 0, 1, 5'b00110, 1);
    step("fl_go", 0, 1, 1, 5'b11100, 1);
    compared++;
    assert (busy === 1'b0 && q_valid === 1'b0) else begin
      mismatched++;
      $error("FAIL flush_const busy/q_valid: got %b/%b want 0/0", busy, q_valid);
    end
    for (int k = 0; k < DEPTH + 1; k++) step("fl_drain", 0, 0, 1, 5'b00000, 0);

    // Full pipeline, then rst, flush and en together: reset wins.
    for (int k = 0; k < DEPTH; k++) step("full", 0, 0, 1, 5'(k + 20), 1);
    step("rst_flush", 1, 1, 1, 5'b11111, 1);
    expect_out("rst_wins_const", 5'b00000, 1'b0, 1'b0);

    // Streaming 1,2,3,...: q follows DEPTH edges behind with q_valid continuously high.
    for (int k = 1; k <= 12; k++) begin
      step("stream", 0, 0, 1, 5'(k), 1);
      if (k >= DEPTH) expect_out("stream_const", 5'(k - DEPTH + 1), 1'b1, 1'b1);
    end

    // Random mix of stall, flush, bubbles and occasional reset.
    for (int k = 0; k < 600; k++) begin
      rd = 5'($urandom);
      step("rand", ($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 5),
           ($urandom_range(0, 99) < 75), rd, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
